// File: rtl/self_test_pkg.sv
// Shared types and constants for the self-test monitor.
package self_test_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } stm_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } stm_verdict_t;

    // Value the test program leaves in x28 when every test passed.
    localparam logic [31:0] PASS_VALUE = 32'h1;

    // Failing test index encoded by the test program as 2*n+1.
    function automatic logic [30:0] failing_test(input logic [31:0] reg_val);
        logic [31:0] dec;
        dec = reg_val - 32'd1;
        return dec[31:1];
    endfunction

endpackage

// File: rtl/stm_fifo.sv
// Synchronous FIFO for console bytes. The head entry is presented through
// registered outputs; a push into an empty FIFO (or onto a FIFO that is about
// to expose the pushed slot) is forwarded straight into the head register.
// DEPTH must be a power of two so the pointers wrap naturally.
module stm_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             push_ok_o,
    output logic             drop_o,
    output logic             empty_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full;
    logic             pop_ok;

    // Accept/drop decision, pointer and occupancy update, next head entry.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        pop_ok    = pop_i && valid_q;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok_o = push_i && (!full || pop_ok);
        drop_o    = push_i && full && !pop_ok;

        wr_ptr_d  = push_ok_o ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok    ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        count_d = count_q;
        if (push_ok_o && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok_o && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end

        valid_d = (count_d != '0);
        // The slot being written this cycle is not yet in the array.
        if (push_ok_o && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Storage array: written on accepted pushes only, no reset so it maps to RAM.
    always_ff @(posedge CLK) begin
        if (push_ok_o) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign empty_o = (count_q == '0);
    assign valid_o = valid_q;
    assign data_o  = head_q;

endmodule

// File: rtl/self_test_monitor.sv
// Self-test monitor: snoops console writes on the core bus into a FIFO and
// latches a pass/fail/timeout verdict on core halt or cycle timeout.
// Optional console checksum is built only when STM_CHECKSUM_EN is defined.
module self_test_monitor
    import self_test_pkg::*;
#(
    parameter logic [31:0] CONSOLE_BASE   = 32'h0000_0000,
    parameter int          NCHAN          = 1,
    parameter int          BYTE_LANE      = 3,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter int          CNT_W          = 32
) (
    input  logic                                        CLK,
    input  logic                                        nRST,
    input  logic [31:0]                                 bus_addr,
    input  logic                                        bus_wen,
    input  logic                                        bus_busy,
    input  logic [3:0]                                  bus_byte_en,
    input  logic [31:0]                                 bus_wdata,
    input  logic                                        halt_i,
    input  logic [31:0]                                 test_reg_i,
    output logic                                        con_valid,
    input  logic                                        con_ready,
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] con_chan,
    output logic [7:0]                                  con_data,
    output logic                                        done,
    output logic                                        pass,
    output logic                                        fail,
    output logic                                        timeout,
    output logic [30:0]                                 fail_test,
    output logic [CNT_W-1:0]                            cycle_count,
    output logic                                        overflow,
    output logic [7:0]                                  checksum
);

    localparam int               CHW          = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int               EW           = CHW + 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    stm_state_t       state_q, state_d;
    stm_verdict_t     verdict_q, verdict_d;
    logic [30:0]      fail_test_q, fail_test_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic [NCHAN-1:0] chan_hit;
    logic             push_req;
    logic [CHW-1:0]   push_chan;
    logic [7:0]       push_char;
    logic             fifo_push_ok;
    logic             fifo_drop;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [EW-1:0]    fifo_head;

    // One exact-address comparator per console channel (alignment is implied).
    genvar gi;
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
        assign chan_hit[gi] = (bus_addr == (CONSOLE_BASE + 32'(4 * gi)));
    end

    // Completed console write while running becomes a FIFO push request.
    always_comb begin
        push_chan = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (chan_hit[i]) begin
                push_chan = CHW'(i);
            end
        end
        push_char = bus_wdata[8*BYTE_LANE +: 8];
        push_req  = (state_q == RUN) && bus_wen && !bus_busy
                    && bus_byte_en[BYTE_LANE] && (|chan_hit);
    end

    stm_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .nRST        (nRST),
        .push_i      (push_req),
        .push_data_i ({push_chan, push_char}),
        .pop_i       (con_ready),
        .push_ok_o   (fifo_push_ok),
        .drop_o      (fifo_drop),
        .empty_o     (fifo_empty),
        .valid_o     (fifo_valid),
        .data_o      (fifo_head)
    );

    // Next-state logic: run counter, verdict capture, drain and completion.
    always_comb begin
        state_d       = state_q;
        verdict_d     = verdict_q;
        fail_test_d   = fail_test_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        overflow_d    = overflow_q | fifo_drop;

        case (state_q)
            RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                // Halt takes priority over a timeout falling in the same cycle.
                if (halt_i) begin
                    state_d = DRAIN;
                    if (test_reg_i == PASS_VALUE) begin
                        verdict_d = PASS;
                    end else begin
                        verdict_d   = FAIL;
                        fail_test_d = failing_test(test_reg_i);
                    end
                end else if (cycle_count_q == TIMEOUT_LAST) begin
                    state_d   = DRAIN;
                    verdict_d = TIMEOUT;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Monitor state registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= RUN;
            verdict_q     <= NONE;
            fail_test_q   <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            verdict_q     <= verdict_d;
            fail_test_q   <= fail_test_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef STM_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // Running negated sum: -(s + b) == -s - b, so subtract each accepted byte.
    always_comb begin
        checksum_d = checksum_q;
        if (fifo_push_ok) begin
            checksum_d = checksum_q - push_char;
        end
    end

    // Checksum register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign con_valid   = fifo_valid;
    assign con_chan    = fifo_head[8 +: CHW];
    assign con_data    = fifo_head[7:0];
    assign done        = done_q;
    assign pass        = (verdict_q == PASS);
    assign fail        = (verdict_q == FAIL);
    assign timeout     = (verdict_q == TIMEOUT);
    assign fail_test   = fail_test_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;

    // Bus bits outside the character lane are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus_wdata, bus_byte_en, fifo_push_ok};

endmodule
